parking_slot_timer: RTL and testbench

Parametrised per-slot parking duration timer, successor to the fixed 4-slot timer. Tracks occupancy and elapsed minutes for `NUM_SLOTS` bays using an internal minute prescaler, and saturates at a configurable maximum. Emits one exit-duration record per departure over a valid/ready handshake, flags overstays, and rotates the HH:MM display across occupied slots only. Sits between the slot sensors/gate logic and the billing and display blocks.

---
 rtl/parking_pkg.sv | 21 ++
 rtl/parking_slot_counter.sv | 52 +++++
 rtl/parking_slot_timer.sv | 169 ++++++++++++++++
 tb/tb_parking_slot_timer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared constants, exit record type and HH:MM formatting for the parking slot timer.
`timescale 1ns/1ps
package parking_pkg;
  localparam int unsigned MIN_PER_HOUR     = 60;
  localparam int          DEF_MAX_MINUTES  = 5999;
  localparam int          DEF_OVERSTAY_MIN = 240;

  // Record fields are sized for the largest supported lot (16 slots, 16-bit minutes).
  localparam int REC_SLOT_W = 4;
  localparam int REC_MIN_W  = 16;

  typedef struct packed {
    logic [REC_SLOT_W-1:0] slot;
    logic [REC_MIN_W-1:0]  minutes;
  } exit_rec_t;

  // {hours, minutes} in binary, one byte each.
  function automatic logic [15:0] fmt_hhmm(input int unsigned m);
    return {8'(m / MIN_PER_HOUR), 8'(m % MIN_PER_HOUR)};
  endfunction
endpackage

// File: rtl/parking_slot_counter.sv
// Per-bay state: occupancy, pending exit record and a saturating minute count.
`timescale 1ns/1ps
module parking_slot_counter
  import parking_pkg::*;
#(
  parameter int MAX_MINUTES = DEF_MAX_MINUTES,
  parameter int MIN_W       = $clog2(MAX_MINUTES + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_entry,
  input  logic             i_exit,
  input  logic             i_min_tick,
  input  logic             i_release,
  output logic             o_occupied,
  output logic             o_pending,
  output logic [MIN_W-1:0] o_minutes
);
  localparam logic [MIN_W-1:0] MAX_VAL = MIN_W'(MAX_MINUTES);

  logic             r_occ;
  logic             r_pend;
  logic [MIN_W-1:0] r_min;

  // Exit wins on an occupied bay; entry only on a bay that is free and has no record waiting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_occ  <= 1'b0;
      r_pend <= 1'b0;
      r_min  <= '0;
    end else if (r_occ) begin
      if (i_exit) begin
        r_occ  <= 1'b0;
        r_pend <= 1'b1;
      end else if (i_min_tick && (r_min != MAX_VAL)) begin
        r_min <= r_min + MIN_W'(1);
      end
    end else if (r_pend) begin
      if (i_release) begin
        r_pend <= 1'b0;
        r_min  <= '0;
      end
    end else if (i_entry) begin
      r_occ <= 1'b1;
      r_min <= '0;
    end
  end

  assign o_occupied = r_occ;
  assign o_pending  = r_pend;
  assign o_minutes  = r_min;
endmodule

// File: rtl/parking_slot_timer.sv
// Parking duration timer: minute prescaler, per-slot counters, exit record arbiter and display rotator.
`timescale 1ns/1ps
module parking_slot_timer
  import parking_pkg::*;
#(
  parameter  int NUM_SLOTS     = 4,
  parameter  int TICKS_PER_MIN = 60_000_000,
  parameter  int DWELL_TICKS   = 15_000_000,
  parameter  int MAX_MINUTES   = DEF_MAX_MINUTES,
  parameter  int OVERSTAY_MIN  = DEF_OVERSTAY_MIN,
  localparam int SLOT_W        = $clog2(NUM_SLOTS),
  localparam int MIN_W         = $clog2(MAX_MINUTES + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_SLOTS-1:0] car_entry,
  input  logic [NUM_SLOTS-1:0] car_exit,
  input  logic                 exit_ready,
  output logic                 exit_valid,
  output logic [SLOT_W-1:0]    exit_slot,
  output logic [MIN_W-1:0]     exit_minutes,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [NUM_SLOTS-1:0] overstay,
  output logic                 display_valid,
  output logic [SLOT_W-1:0]    display_slot,
  output logic [15:0]          display_time
);
  localparam int PRE_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int DWL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MIN - 1);
  localparam logic [DWL_W-1:0] DWL_LAST = DWL_W'(DWELL_TICKS - 1);

  logic [PRE_W-1:0]     r_presc;
  logic                 w_min_tick;
  logic [NUM_SLOTS-1:0] w_occ, w_pend, w_release, w_avail, w_over;
  logic [MIN_W-1:0]     w_min [NUM_SLOTS];
  exit_rec_t            w_pick;
  logic                 w_pick_vld;
  logic                 r_exit_valid;
  logic [SLOT_W-1:0]    r_exit_slot;
  logic [MIN_W-1:0]     r_exit_min;
  logic [NUM_SLOTS-1:0] r_overstay;
  logic [SLOT_W-1:0]    r_disp_slot, w_disp_slot_nxt;
  logic [DWL_W-1:0]     r_dwell, w_dwell_nxt;
  logic                 r_disp_valid;
  logic [15:0]          r_disp_time;

  // First occupied slot after cur, wrapping around; cur itself is the last candidate.
  function automatic logic [SLOT_W-1:0] next_occupied(input logic [SLOT_W-1:0] cur,
                                                      input logic [NUM_SLOTS-1:0] occ);
    logic [SLOT_W-1:0] pick;
    logic              found;
    int                idx;
    pick  = cur;
    found = 1'b0;
    for (int k = 1; k <= NUM_SLOTS; k++) begin
      idx = (int'(cur) + k) % NUM_SLOTS;
      if (!found && occ[idx]) begin
        pick  = SLOT_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign w_min_tick = (r_presc == PRE_LAST);

  // Free-running minute prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_presc <= '0;
    else          r_presc <= w_min_tick ? '0 : r_presc + PRE_W'(1);
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    parking_slot_counter #(
      .MAX_MINUTES (MAX_MINUTES),
      .MIN_W       (MIN_W)
    ) u_slot (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_entry    (car_entry[g]),
      .i_exit     (car_exit[g]),
      .i_min_tick (w_min_tick),
      .i_release  (w_release[g]),
      .o_occupied (w_occ[g]),
      .o_pending  (w_pend[g]),
      .o_minutes  (w_min[g])
    );
  end

  // Lowest-index pending slot, excluding the one whose record is being accepted this cycle.
  always_comb begin
    w_release = '0;
    if (r_exit_valid && exit_ready) w_release[r_exit_slot] = 1'b1;
    w_avail    = w_pend & ~w_release;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (w_avail[i]) begin
        w_pick_vld     = 1'b1;
        w_pick.slot    = REC_SLOT_W'(i);
        w_pick.minutes = REC_MIN_W'(w_min[i]);
      end
    end
  end

  // Record register: held while stalled, reloaded when empty or on a handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exit_valid <= 1'b0;
      r_exit_slot  <= '0;
      r_exit_min   <= '0;
    end else if (!r_exit_valid || exit_ready) begin
      r_exit_valid <= w_pick_vld;
      r_exit_slot  <= w_pick.slot[SLOT_W-1:0];
      r_exit_min   <= w_pick.minutes[MIN_W-1:0];
    end
  end

  // Overstay threshold compare per slot.
  always_comb begin
    w_over = '0;
    for (int i = 0; i < NUM_SLOTS; i++) w_over[i] = w_occ[i] && (int'(w_min[i]) >= OVERSTAY_MIN);
  end

  // Registered overstay flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_overstay <= '0;
    else          r_overstay <= w_over;
  end

  // Display rotation: advance on dwell expiry or immediately when the shown slot is vacated.
  always_comb begin
    w_disp_slot_nxt = r_disp_slot;
    w_dwell_nxt     = r_dwell;
    if (!(|w_occ)) begin
      w_dwell_nxt = '0;
    end else if (!w_occ[r_disp_slot] || (r_dwell == DWL_LAST)) begin
      w_disp_slot_nxt = next_occupied(r_disp_slot, w_occ);
      w_dwell_nxt     = '0;
    end else begin
      w_dwell_nxt = r_dwell + DWL_W'(1);
    end
  end

  // Display registers; time is formatted from the slot about to be shown so slot and time agree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_disp_slot  <= '0;
      r_dwell      <= '0;
      r_disp_valid <= 1'b0;
      r_disp_time  <= '0;
    end else begin
      r_disp_slot  <= w_disp_slot_nxt;
      r_dwell      <= w_dwell_nxt;
      r_disp_valid <= |w_occ;
      r_disp_time  <= (|w_occ) ? fmt_hhmm(32'(w_min[w_disp_slot_nxt])) : 16'h0000;
    end
  end

  assign exit_valid    = r_exit_valid;
  assign exit_slot     = r_exit_slot;
  assign exit_minutes  = r_exit_min;
  assign occupied      = w_occ;
  assign overstay      = r_overstay;
  assign display_valid = r_disp_valid;
  assign display_slot  = r_disp_slot;
  assign display_time  = r_disp_time;
endmodule

// File: tb/tb_parking_slot_timer.sv
// Directed testbench for parking_slot_timer with small timing parameters.
`timescale 1ns/1ps
module tb_parking_slot_timer;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  car_entry, car_exit;
  logic        exit_ready;
  logic        exit_valid;
  logic [1:0]  exit_slot;
  logic [3:0]  exit_minutes;
  logic [3:0]  occupied, overstay;
  logic        display_valid;
  logic [1:0]  display_slot;
  logic [15:0] display_time;

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  logic [1:0] tb_presc;

  parking_slot_timer #(
    .NUM_SLOTS     (4),
    .TICKS_PER_MIN (4),
    .DWELL_TICKS   (8),
    .MAX_MINUTES   (10),
    .OVERSTAY_MIN  (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .car_entry     (car_entry),
    .car_exit      (car_exit),
    .exit_ready    (exit_ready),
    .exit_valid    (exit_valid),
    .exit_slot     (exit_slot),
    .exit_minutes  (exit_minutes),
    .occupied      (occupied),
    .overstay      (overstay),
    .display_valid (display_valid),
    .display_slot  (display_slot),
    .display_time  (display_time)
  );

  always #5 clk = ~clk;

  // Reference minute phase: 4 ticks per minute, so a 2-bit counter wraps exactly at the terminal count.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_presc <= 2'd0;
    else          tb_presc <= tb_presc + 2'd1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    car_entry  = '0;
    car_exit   = '0;
    exit_ready = 1'b0;
    reset_n    = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Cycle 0 is a cycle whose prescaler count is 0; minute ticks then end cycles 3, 7, 11, ...
  task automatic align();
    for (int i = 0; i < 4 && tb_presc != 2'd0; i++) step();
    cyc = 0;
  endtask

  task automatic test_reset();
    car_entry  = '0;
    car_exit   = '0;
    exit_ready = 1'b0;
    reset_n    = 1'b0;
    step();
    step();
    vecs++;
    if ({exit_valid, exit_slot, exit_minutes} !== 7'd0) begin
      errs++; $display("FAIL reset_exit: got %h want 0", {exit_valid, exit_slot, exit_minutes});
    end
    vecs++;
    if ({occupied, overstay} !== 8'd0) begin
      errs++; $display("FAIL reset_slots: got %h want 0", {occupied, overstay});
    end
    vecs++;
    if ({display_valid, display_slot, display_time} !== 19'd0) begin
      errs++; $display("FAIL reset_display: got %h want 0", {display_valid, display_slot, display_time});
    end
    reset_n = 1'b1;
  endtask

  task automatic test_entry_exit();
    int n;
    do_reset(); align();
    car_entry = 4'b0100; step(); car_entry = '0;
    vecs++;
    if (occupied !== 4'b0100) begin errs++; $display("FAIL ee_occ: got %b want 0100", occupied); end
    step();
    vecs++;
    if ({display_valid, display_slot} !== {1'b1, 2'd2}) begin
      errs++; $display("FAIL ee_disp_jump: got %b/%0d want 1/2", display_valid, display_slot);
    end
    step_to(12);
    vecs++;
    if (overstay !== 4'b0000) begin errs++; $display("FAIL ee_overstay_early: got %b want 0000", overstay); end
    step_to(13);
    vecs++;
    if (overstay !== 4'b0100) begin errs++; $display("FAIL ee_overstay: got %b want 0100", overstay); end
    vecs++;
    if (display_time !== 16'h0003) begin errs++; $display("FAIL ee_disp_time: got %h want 0003", display_time); end
    step_to(20);
    exit_ready = 1'b1;
    car_exit = 4'b0100; step(); car_exit = '0;
    vecs++;
    if ({occupied, exit_valid} !== 5'b0000_0) begin
      errs++; $display("FAIL ee_exit_occ: got %b/%b want 0000/0", occupied, exit_valid);
    end
    step();
    vecs++;
    if ({exit_valid, exit_slot, exit_minutes} !== {1'b1, 2'd2, 4'd5}) begin
      errs++; $display("FAIL ee_record: got v%b s%0d m%0d want v1 s2 m5", exit_valid, exit_slot, exit_minutes);
    end
    vecs++;
    if (overstay !== 4'b0000) begin errs++; $display("FAIL ee_overstay_clr: got %b want 0000", overstay); end
    n = 1;
    for (int i = 0; i < 8; i++) begin step(); if (exit_valid) n++; end
    vecs++;
    if (n !== 1) begin errs++; $display("FAIL ee_record_count: got %0d want 1", n); end
  endtask

  task automatic test_saturation();
    do_reset(); align();
    car_entry = 4'b0001; step(); car_entry = '0;
    step_to(37);
    vecs++;
    if (display_time !== 16'h0009) begin errs++; $display("FAIL sat_pre: got %h want 0009", display_time); end
    step_to(70);
    vecs++;
    if ({display_slot, display_time} !== {2'd0, 16'h000A}) begin
      errs++; $display("FAIL sat_disp: got %0d/%h want 0/000A", display_slot, display_time);
    end
    vecs++;
    if (overstay !== 4'b0001) begin errs++; $display("FAIL sat_overstay: got %b want 0001", overstay); end
    exit_ready = 1'b1;
    car_exit = 4'b0001; step(); car_exit = '0;
    step();
    vecs++;
    if ({exit_valid, exit_slot, exit_minutes} !== {1'b1, 2'd0, 4'd10}) begin
      errs++; $display("FAIL sat_record: got v%b s%0d m%0d want v1 s0 m10", exit_valid, exit_slot, exit_minutes);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); align();
    car_entry = 4'b1010; step(); car_entry = '0;
    step_to(10);
    car_exit = 4'b1010; step(); car_exit = '0;
    vecs++;
    if (occupied !== 4'b0000) begin errs++; $display("FAIL b2b_occ: got %b want 0000", occupied); end
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exit_ready = 1'b0;
      vecs++;
      if ({exit_valid, exit_slot, exit_minutes} !== {1'b1, 2'd1, 4'd2}) begin
        errs++; $display("FAIL b2b_hold%0d: got v%b s%0d m%0d want v1 s1 m2", i, exit_valid, exit_slot, exit_minutes);
      end
      if (i == 3) exit_ready = 1'b1;
      step();
    end
    vecs++;
    if ({exit_valid, exit_slot, exit_minutes} !== {1'b1, 2'd3, 4'd2}) begin
      errs++; $display("FAIL b2b_second: got v%b s%0d m%0d want v1 s3 m2", exit_valid, exit_slot, exit_minutes);
    end
    step();
    vecs++;
    if (exit_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain: got %b want 0", exit_valid); end
  endtask

  task automatic test_same_cycle();
    do_reset(); align();
    car_entry = 4'b0001; step();
    car_exit = 4'b0001; step();
    car_entry = '0; car_exit = '0;
    vecs++;
    if (occupied !== 4'b0000) begin errs++; $display("FAIL sc_exit_wins: got %b want 0000", occupied); end
    step();
    vecs++;
    if ({exit_valid, exit_slot, exit_minutes} !== {1'b1, 2'd0, 4'd0}) begin
      errs++; $display("FAIL sc_record: got v%b s%0d m%0d want v1 s0 m0", exit_valid, exit_slot, exit_minutes);
    end
    car_entry = 4'b0001; step(); car_entry = '0;
    vecs++;
    if ({occupied, exit_valid} !== 5'b0000_1) begin
      errs++; $display("FAIL sc_pending_entry: got %b/%b want 0000/1", occupied, exit_valid);
    end
    exit_ready = 1'b1; step();
    vecs++;
    if (exit_valid !== 1'b0) begin errs++; $display("FAIL sc_accepted: got %b want 0", exit_valid); end
    car_entry = 4'b0001; car_exit = 4'b0001; step();
    car_entry = '0; car_exit = '0;
    vecs++;
    if (occupied !== 4'b0001) begin errs++; $display("FAIL sc_entry_wins: got %b want 0001", occupied); end
    step();
    vecs++;
    if (exit_valid !== 1'b0) begin errs++; $display("FAIL sc_no_record: got %b want 0", exit_valid); end
  endtask

  task automatic test_display_rotation();
    do_reset(); align();
    exit_ready = 1'b1;
    car_entry = 4'b0101; step(); car_entry = '0;
    step_to(8);
    vecs++;
    if (display_slot !== 2'd0) begin errs++; $display("FAIL rot_c8: got %0d want 0", display_slot); end
    step_to(9);
    vecs++;
    if (display_slot !== 2'd2) begin errs++; $display("FAIL rot_c9: got %0d want 2", display_slot); end
    step_to(16);
    vecs++;
    if (display_slot !== 2'd2) begin errs++; $display("FAIL rot_c16: got %0d want 2", display_slot); end
    step_to(17);
    vecs++;
    if (display_slot !== 2'd0) begin errs++; $display("FAIL rot_c17: got %0d want 0", display_slot); end
    step_to(25);
    vecs++;
    if (display_slot !== 2'd2) begin errs++; $display("FAIL rot_c25: got %0d want 2", display_slot); end
    car_exit = 4'b0100; step(); car_exit = '0;
    step();
    vecs++;
    if ({display_slot, display_time} !== {2'd0, 16'h0006}) begin
      errs++; $display("FAIL rot_vacate: got %0d/%h want 0/0006", display_slot, display_time);
    end
    car_exit = 4'b0001; step(); car_exit = '0;
    step();
    vecs++;
    if ({display_valid, display_slot, display_time} !== {1'b0, 2'd0, 16'h0000}) begin
      errs++; $display("FAIL rot_empty: got %b/%0d/%h want 0/0/0000", display_valid, display_slot, display_time);
    end
  endtask

  task automatic test_reset_pending();
    int n;
    do_reset(); align();
    car_entry = 4'b0010; step(); car_entry = '0;
    step_to(4);
    car_exit = 4'b0010; step(); car_exit = '0;
    step();
    vecs++;
    if (exit_valid !== 1'b1) begin errs++; $display("FAIL rp_before: got %b want 1", exit_valid); end
    reset_n = 1'b0;
    #1;
    vecs++;
    if ({exit_valid, exit_slot, exit_minutes, occupied, overstay, display_valid, display_slot, display_time} !== 34'd0) begin
      errs++; $display("FAIL rp_async_clear: got %h want 0",
                       {exit_valid, exit_slot, exit_minutes, occupied, overstay, display_valid, display_slot, display_time});
    end
    step();
    reset_n    = 1'b1;
    exit_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin step(); if (exit_valid || (occupied != 4'b0000)) n++; end
    vecs++;
    if (n !== 0) begin errs++; $display("FAIL rp_no_record: got %0d active cycles want 0", n); end
  endtask

  initial begin
    car_entry  = '0;
    car_exit   = '0;
    exit_ready = 1'b0;
    reset_n    = 1'b0;
    test_reset();
    test_entry_exit();
    test_saturation();
    test_back_to_back();
    test_same_cycle();
    test_display_rotation();
    test_reset_pending();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
